acc_stack: RTL and testbench

Parametrised successor to the processor's single accumulator register. It selects one of NUM_SRC source buses into a WIDTH-bit accumulator, as the single accumulator does. It adds a DEPTH-entry save/restore stack so the datapath can push the accumulator around subroutine-style sequences and pop it back. It also flags overflow/underflow misuse. Sits between the source buses (immediate, register file, data memory, ALU, …) and every consumer of the accumulator value.

---
 rtl/acc_pkg.sv | 22 ++
 rtl/mux_n.sv | 20 ++
 rtl/acc_stack.sv | 122 ++++++++++++
 tb/tb_acc_stack.sv | 137 +++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types for the accumulator/stack block: the command decoded from push/pop.
package acc_pkg;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_PUSH,
        CMD_POP,
        CMD_SWAP
    } cmd_e;

    function automatic cmd_e decode_cmd(input logic push, input logic pop);
        cmd_e c;
        case ({push, pop})
            2'b10:   c = CMD_PUSH;
            2'b01:   c = CMD_POP;
            2'b11:   c = CMD_SWAP;
            default: c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mux_n.sv
// N-way source select; any select value past the last source falls back to source 0.
module mux_n #(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 4,
    parameter int SELW    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC*WIDTH-1:0] src_i,
    input  logic [SELW-1:0]          sel_i,
    output logic [WIDTH-1:0]         y_o
);

    always_comb begin
        y_o = src_i[0 +: WIDTH];
        for (int i = 1; i < NUM_SRC; i++) begin
            if (sel_i == SELW'(i))
                y_o = src_i[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/acc_stack.sv
// Accumulator with source select and a DEPTH-entry save/restore stack.
// Illegal stack use sets a sticky error flag; state changes land one cycle after sampling.
module acc_stack
    import acc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_SRC*WIDTH-1:0]   src_data,
    input  logic [$clog2(NUM_SRC)-1:0] src_sel,
    input  logic                       acc_write,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           acc_out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       stack_err
);

    localparam int SELW = $clog2(NUM_SRC);
    localparam int DW   = $clog2(DEPTH+1);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             err_q, err_d;

    // Storage is rounded up to a power of two so depth-derived indices never go out of range.
    logic [WIDTH-1:0] stack_q [2**AW];

    logic [WIDTH-1:0] src_val;
    logic [AW-1:0]    push_idx, top_idx, stk_widx;
    logic [WIDTH-1:0] stk_wdata;
    logic             stk_we, err_set;
    cmd_e             cmd;

    mux_n #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SELW    (SELW)
    ) u_mux (
        .src_i (src_data),
        .sel_i (src_sel),
        .y_o   (src_val)
    );

    assign cmd      = decode_cmd(push, pop);
    assign full     = (depth_q == FULL_CNT);
    assign empty    = (depth_q == '0);
    assign push_idx = AW'(depth_q);
    assign top_idx  = AW'(depth_q - DW'(1));

    always_comb begin
        acc_d     = acc_q;
        depth_d   = depth_q;
        err_set   = 1'b0;
        stk_we    = 1'b0;
        stk_widx  = push_idx;
        stk_wdata = acc_q;
        case (cmd)
            CMD_NONE: begin
                if (acc_write) acc_d = src_val;
            end
            CMD_PUSH: begin
                if (acc_write) acc_d = src_val;
                if (full) begin
                    err_set = 1'b1;
                end else begin
                    stk_we  = 1'b1;
                    depth_d = depth_q + DW'(1);
                end
            end
            CMD_POP: begin
                if (empty) begin
                    err_set = 1'b1;
                end else begin
                    acc_d   = stack_q[top_idx];
                    depth_d = depth_q - DW'(1);
                end
            end
            CMD_SWAP: begin
                if (empty) begin
                    err_set = 1'b1;
                end else begin
                    acc_d    = stack_q[top_idx];
                    stk_we   = 1'b1;
                    stk_widx = top_idx;
                end
            end
            default: ;
        endcase
        err_d = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && stk_we)
            stack_q[stk_widx] <= stk_wdata;
    end

    assign acc_out   = acc_q;
    assign depth     = depth_q;
    assign stack_err = err_q;

endmodule

// File: tb/tb_acc_stack.sv
// Directed scoreboard bench for acc_stack: driver queues expectations, monitor checks each cycle.
module tb_acc_stack;

    localparam int W  = 8;
    localparam int NS = 5;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NS*W-1:0] src_data = '0;
    logic [2:0]    src_sel = '0;
    logic          acc_write = 1'b0, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
    logic [W-1:0]  acc_out;
    logic [2:0]    depth;
    logic          full, empty, stack_err;

    acc_stack #(.WIDTH(W), .NUM_SRC(NS), .DEPTH(D)) dut (
        .CLK(clk), .RESET(rst), .src_data(src_data), .src_sel(src_sel),
        .acc_write(acc_write), .push(push), .pop(pop), .err_clr(err_clr),
        .acc_out(acc_out), .depth(depth), .full(full), .empty(empty),
        .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [7:0] acc;
        int         dep;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   drv_done = 1'b0;

    // Drive at negedge; result is due after the following posedge.
    task automatic step(input string nm, input logic r, input logic wr, input logic [2:0] sel,
                        input logic [7:0] val, input logic ps, input logic pp, input logic clr,
                        input logic [7:0] eacc, input int edep, input logic eerr);
        exp_t e;
        @(negedge clk);
        rst = r; acc_write = wr; src_sel = sel; push = ps; pop = pp; err_clr = clr;
        if (sel < 3'(NS)) src_data[sel*W +: W] = val;
        e.nm = nm; e.acc = eacc; e.dep = edep; e.err = eerr;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (acc_out !== e.acc || int'(depth) != e.dep || full !== (e.dep == D) ||
                    empty !== (e.dep == 0) || stack_err !== e.err) begin
                    n_bad++;
                    $display("FAIL %s: got acc=%02h depth=%0d full=%b empty=%b err=%b, want acc=%02h depth=%0d full=%b empty=%b err=%b",
                             e.nm, acc_out, depth, full, empty, stack_err,
                             e.acc, e.dep, (e.dep == D), (e.dep == 0), e.err);
                end
            end
        end
    end

    initial begin : driver
        //    name          rst wr sel  val    ps pp clr  acc    dep err
        step("reset",        1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        step("load_src2",    0, 1, 2, 8'h5A, 0, 0, 0, 8'h5A, 0, 0);
        step("load_11",      0, 1, 1, 8'h11, 0, 0, 0, 8'h11, 0, 0);
        step("push_11",      0, 0, 0, 8'h00, 1, 0, 0, 8'h11, 1, 0);
        step("load_22",      0, 1, 0, 8'h22, 0, 0, 0, 8'h22, 1, 0);
        step("push_22",      0, 0, 0, 8'h00, 1, 0, 0, 8'h22, 2, 0);
        step("load_33",      0, 1, 3, 8'h33, 0, 0, 0, 8'h33, 2, 0);
        step("pop_22",       0, 0, 0, 8'h00, 0, 1, 0, 8'h22, 1, 0);
        step("pop_11",       0, 0, 0, 8'h00, 0, 1, 0, 8'h11, 0, 0);
        step("pop_empty",    0, 0, 0, 8'h00, 0, 1, 0, 8'h11, 0, 1);
        step("clr_1",        0, 0, 0, 8'h00, 0, 0, 1, 8'h11, 0, 0);
        step("swap_empty",   0, 0, 0, 8'h00, 1, 1, 0, 8'h11, 0, 1);
        step("clr_2",        0, 0, 0, 8'h00, 0, 0, 1, 8'h11, 0, 0);
        step("fill_1",       0, 0, 0, 8'h00, 1, 0, 0, 8'h11, 1, 0);
        step("fill_2",       0, 0, 0, 8'h00, 1, 0, 0, 8'h11, 2, 0);
        step("fill_3",       0, 0, 0, 8'h00, 1, 0, 0, 8'h11, 3, 0);
        step("fill_4",       0, 0, 0, 8'h00, 1, 0, 0, 8'h11, 4, 0);
        step("push_full",    0, 0, 0, 8'h00, 1, 0, 0, 8'h11, 4, 1);
        step("clr_full",     0, 0, 0, 8'h00, 0, 0, 1, 8'h11, 4, 0);
        step("clr_vs_err",   0, 1, 3, 8'h44, 1, 0, 1, 8'h44, 4, 1);
        step("clr_3",        0, 0, 0, 8'h00, 0, 0, 1, 8'h44, 4, 0);
        step("pop_to_3",     0, 0, 0, 8'h00, 0, 1, 0, 8'h11, 3, 0);
        step("reset_push",   1, 1, 1, 8'h9C, 1, 0, 0, 8'h00, 0, 0);
        step("pop_post_rst", 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 1);
        step("clr_4",        0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
        step("load_55",      0, 1, 4, 8'h55, 0, 0, 0, 8'h55, 0, 0);
        step("push_55",      0, 0, 0, 8'h00, 1, 0, 0, 8'h55, 1, 0);
        step("load_AA",      0, 1, 2, 8'hAA, 0, 0, 0, 8'hAA, 1, 0);
        step("swap",         0, 0, 0, 8'h00, 1, 1, 0, 8'h55, 1, 0);
        step("pop_swapped",  0, 0, 0, 8'h00, 0, 1, 0, 8'hAA, 0, 0);
        step("load_10",      0, 1, 1, 8'h10, 0, 0, 0, 8'h10, 0, 0);
        step("push_wr_77",   0, 1, 2, 8'h77, 1, 0, 0, 8'h77, 1, 0);
        step("pop_10",       0, 0, 0, 8'h00, 0, 1, 0, 8'h10, 0, 0);
        step("load_66",      0, 1, 3, 8'h66, 0, 0, 0, 8'h66, 0, 0);
        step("push_66",      0, 0, 0, 8'h00, 1, 0, 0, 8'h66, 1, 0);
        step("load_99",      0, 1, 4, 8'h99, 0, 0, 0, 8'h99, 1, 0);
        step("pop_wins",     0, 1, 1, 8'hEE, 0, 1, 0, 8'h66, 0, 0);
        step("load_src0",    0, 1, 0, 8'hC3, 0, 0, 0, 8'hC3, 0, 0);
        step("load_01",      0, 1, 1, 8'h01, 0, 0, 0, 8'h01, 0, 0);
        step("sel_5_oor",    0, 1, 5, 8'h00, 0, 0, 0, 8'hC3, 0, 0);
        step("load_02",      0, 1, 1, 8'h02, 0, 0, 0, 8'h02, 0, 0);
        step("sel_7_oor",    0, 1, 7, 8'h00, 0, 0, 0, 8'hC3, 0, 0);
        step("b2b_push",     0, 0, 0, 8'h00, 1, 0, 0, 8'hC3, 1, 0);
        step("b2b_load",     0, 1, 1, 8'h3C, 1, 0, 0, 8'h3C, 2, 0);
        step("b2b_pop1",     0, 0, 0, 8'h00, 0, 1, 0, 8'hC3, 1, 0);
        step("b2b_pop2",     0, 0, 0, 8'h00, 0, 1, 0, 8'hC3, 0, 0);
        @(negedge clk);
        acc_write = 0; push = 0; pop = 0; err_clr = 0;
        drv_done = 1'b1;
    end

    initial begin : finisher
        int t;
        t = 0;
        while (!(drv_done && exp_q.size() == 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || !drv_done) begin
            n_bad++;
            $display("FAIL timeout: %0d expectations still pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
